// File: rtl/ccff_chain_loader_pkg.sv
// rtl/ccff_chain_loader_pkg.sv - shared types and default sizes for the ccff chain loader
// Contents: ccff_state_e (loader FSM states), default CHAIN_LEN / WORD_W.
package ccff_chain_loader_pkg;

   localparam int CHAIN_LEN_DEF = 10;
   localparam int WORD_W_DEF    = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } ccff_state_e;

endpackage

// File: rtl/ccff_chain_loader_if.sv
// rtl/ccff_chain_loader_if.sv - bitstream word handshake between host/loader and chain loader
// Signals: bs_data (word, LSB shifted first), bs_valid (word valid), bs_ready (loader accepts).
// Modports: master drives data/valid, slave drives ready.
interface ccff_chain_loader_if
   import ccff_chain_loader_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF
);
   logic [WORD_W-1:0] bs_data;
   logic              bs_valid;
   logic              bs_ready;

   modport master (output bs_data, output bs_valid, input bs_ready);
   modport slave  (input bs_data, input bs_valid, output bs_ready);
endinterface

// File: rtl/ccff_chain_loader_word_serializer.sv
// rtl/ccff_chain_loader_word_serializer.sv - word shift register and bit index for the chain loader
// Ports: prog_clk, pReset (sync, active high), load (capture word), shift (advance one bit),
//        word (input word), head_nxt (bit that will drive ccff_head next cycle),
//        last_bit (current bit is the word's MSB).
module ccff_chain_loader_word_serializer #(
   parameter int WORD_W = 8,
   localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] word,
   output logic              head_nxt,
   output logic              last_bit
);
   logic [WORD_W-1:0] shreg;
   logic [WORD_W-1:0] shreg_shifted;
   logic [IDX_W-1:0]  bit_idx;

   assign shreg_shifted = shreg >> 1;
   assign last_bit      = (bit_idx == IDX_W'(WORD_W - 1));
   // The top registers ccff_head, so it needs the bit that becomes current after this edge.
   assign head_nxt      = load ? word[0] : shreg_shifted[0];

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         shreg   <= '0;
         bit_idx <= '0;
      end else if (load) begin
         shreg   <= word;
         bit_idx <= '0;
      end else if (shift) begin
         shreg <= shreg_shifted;
         if (!last_bit) begin
            bit_idx <= bit_idx + IDX_W'(1);
         end
      end
   end
endmodule

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serialises a bitstream into the ccff configuration chain
// Ports: prog_clk, pReset (sync, active high), start, abort, bs (word handshake, slave side),
//        ccff_head / ccff_clk_en (serial data and gate enable into the chain), ccff_tail (chain out),
//        busy, done (pulse), cfg_loaded (level), aborted (pulse), tail_parity (XOR of outgoing bits).
module ccff_chain_loader
   import ccff_chain_loader_pkg::*;
#(
   parameter int CHAIN_LEN = CHAIN_LEN_DEF,
   parameter int WORD_W    = WORD_W_DEF,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic                 prog_clk,
   input  logic                 pReset,
   input  logic                 start,
   input  logic                 abort,
   ccff_chain_loader_if.slave   bs,
   output logic                 ccff_head,
   output logic                 ccff_clk_en,
   input  logic                 ccff_tail,
   output logic                 busy,
   output logic                 done,
   output logic                 cfg_loaded,
   output logic                 aborted,
   output logic                 tail_parity
);
   ccff_state_e      state;
   logic [CNT_W-1:0] bit_cnt;
   logic             accept;
   logic             do_shift;
   logic             head_nxt;
   logic             last_bit;
   logic             last_chain_bit;

   assign accept         = (state == ST_LOAD) && bs.bs_valid && bs.bs_ready && !abort;
   assign do_shift       = (state == ST_SHIFT) && !abort;
   assign last_chain_bit = (bit_cnt == CNT_W'(CHAIN_LEN - 1));

   ccff_chain_loader_word_serializer #(.WORD_W(WORD_W)) u_ser (
      .prog_clk (prog_clk),
      .pReset   (pReset),
      .load     (accept),
      .shift    (do_shift),
      .word     (bs.bs_data),
      .head_nxt (head_nxt),
      .last_bit (last_bit)
   );

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         state       <= ST_IDLE;
         bit_cnt     <= '0;
         bs.bs_ready <= 1'b0;
         ccff_head   <= 1'b0;
         ccff_clk_en <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         cfg_loaded  <= 1'b0;
         aborted     <= 1'b0;
         tail_parity <= 1'b0;
      end else begin
         done    <= 1'b0;
         aborted <= 1'b0;
         if (state != ST_IDLE && abort) begin
            // Abort beats every other event, including the final shift edge.
            state       <= ST_IDLE;
            bs.bs_ready <= 1'b0;
            ccff_head   <= 1'b0;
            ccff_clk_en <= 1'b0;
            busy        <= 1'b0;
            aborted     <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start && !abort) begin
                     state       <= ST_LOAD;
                     bit_cnt     <= '0;
                     tail_parity <= 1'b0;
                     cfg_loaded  <= 1'b0;
                     bs.bs_ready <= 1'b1;
                     busy        <= 1'b1;
                  end
               end
               ST_LOAD: begin
                  if (accept) begin
                     state       <= ST_SHIFT;
                     bs.bs_ready <= 1'b0;
                     ccff_head   <= head_nxt;
                     ccff_clk_en <= 1'b1;
                  end
               end
               ST_SHIFT: begin
                  // The chain captures ccff_head on this edge; the old tail bit leaves now.
                  bit_cnt     <= bit_cnt + CNT_W'(1);
                  tail_parity <= tail_parity ^ ccff_tail;
                  if (last_chain_bit) begin
                     state       <= ST_DONE;
                     ccff_head   <= 1'b0;
                     ccff_clk_en <= 1'b0;
                     done        <= 1'b1;
                  end else if (last_bit) begin
                     state       <= ST_LOAD;
                     ccff_head   <= 1'b0;
                     ccff_clk_en <= 1'b0;
                     bs.bs_ready <= 1'b1;
                  end else begin
                     ccff_head <= head_nxt;
                  end
               end
               ST_DONE: begin
                  state      <= ST_IDLE;
                  cfg_loaded <= 1'b1;
                  busy       <= 1'b0;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - self-checking bench for ccff_chain_loader with a gated shift-chain model
module tb_ccff_chain_loader;
   localparam int CHAIN_LEN = 10;
   localparam int WORD_W    = 8;
   localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;

   logic prog_clk = 1'b0;
   logic pReset;
   logic start;
   logic abort;
   logic ccff_head, ccff_clk_en, ccff_tail;
   logic busy, done, cfg_loaded, aborted, tail_parity;

   int checks   = 0;
   int failures = 0;

   ccff_chain_loader_if #(.WORD_W(WORD_W)) bs ();

   ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
      .prog_clk    (prog_clk),
      .pReset      (pReset),
      .start       (start),
      .abort       (abort),
      .bs          (bs),
      .ccff_head   (ccff_head),
      .ccff_clk_en (ccff_clk_en),
      .ccff_tail   (ccff_tail),
      .busy        (busy),
      .done        (done),
      .cfg_loaded  (cfg_loaded),
      .aborted     (aborted),
      .tail_parity (tail_parity)
   );

   always #5 prog_clk = ~prog_clk;

   // Behavioural chain on the gated clock: chain[0] sits next to ccff_head.
   logic [CHAIN_LEN-1:0] chain = '0;
   always @(posedge prog_clk) begin
      if (ccff_clk_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
   end
   assign ccff_tail = chain[CHAIN_LEN-1];

   typedef struct {
      logic [WORD_W-1:0]    w0;
      logic [WORD_W-1:0]    w1;
      int                   g0;
      int                   g1;
      logic [CHAIN_LEN-1:0] exp_seq;
      int                   exp_lat;
      logic                 exp_par;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Chain contents in shift order: bit i is the i-th bit shifted in.
   function automatic logic [CHAIN_LEN-1:0] chain_order();
      logic [CHAIN_LEN-1:0] v;
      for (int i = 0; i < CHAIN_LEN; i++) v[i] = chain[CHAIN_LEN-1-i];
      return v;
   endfunction

   function automatic logic [CHAIN_LEN-1:0] model_seq(input logic [WORD_W-1:0] w0,
                                                      input logic [WORD_W-1:0] w1);
      logic [2*WORD_W-1:0] stream;
      stream = {w1, w0};
      return stream[CHAIN_LEN-1:0];
   endfunction

   task automatic do_load(input string nm, input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1,
                          input int g0, input int g1, input bit poke,
                          input logic [CHAIN_LEN-1:0] exp_seq, input int exp_lat, input logic exp_par);
      logic [WORD_W-1:0]    words [NWORDS];
      int                   gaps  [NWORDS];
      logic [CHAIN_LEN-1:0] seq;
      int idx, gl, lat, ens, dones, stray_ready, stray_busy;
      bit poked;
      words[0] = w0; words[1] = w1;
      gaps[0]  = g0; gaps[1]  = g1;
      idx = 0; gl = gaps[0]; lat = -1; seq = '0; ens = 0; dones = 0;
      stray_ready = 0; stray_busy = 0; poked = 0;
      @(negedge prog_clk);
      start = 1'b1;
      for (int c = 2; c <= 300 && lat < 0; c++) begin
         @(negedge prog_clk);
         start = 1'b0;
         if (ccff_clk_en) begin
            if (ens < CHAIN_LEN) seq[ens] = ccff_head;
            ens++;
            if (poke && !poked) begin start = 1'b1; poked = 1; end
         end
         if (done) begin
            dones++;
            lat = c;
            if (poke) start = 1'b1;
         end
         if (idx < NWORDS) begin
            if (bs.bs_ready && gl > 0) begin
               bs.bs_valid = 1'b0;
               gl--;
            end else begin
               bs.bs_valid = 1'b1;
               bs.bs_data  = words[idx];
            end
            if (bs.bs_ready && bs.bs_valid) begin
               idx++;
               if (idx < NWORDS) gl = gaps[idx];
            end
         end else begin
            bs.bs_valid = 1'b0;
         end
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge prog_clk);
         start       = 1'b0;
         bs.bs_valid = 1'b1;
         if (ccff_clk_en) ens++;
         if (done)        dones++;
         if (bs.bs_ready) stray_ready++;
         if (busy)        stray_busy++;
      end
      bs.bs_valid = 1'b0;
      chk({nm, ".latency"},     lat,              exp_lat);
      chk({nm, ".head_seq"},    seq,              exp_seq);
      chk({nm, ".enables"},     ens,              CHAIN_LEN);
      chk({nm, ".done_count"},  dones,            1);
      chk({nm, ".tail_parity"}, tail_parity,      exp_par);
      chk({nm, ".chain"},       chain_order(),    exp_seq);
      chk({nm, ".cfg_loaded"},  cfg_loaded,       1'b1);
      chk({nm, ".stray_ready"}, stray_ready,      0);
      chk({nm, ".stray_busy"},  stray_busy,       0);
   endtask

   // Starts a load and raises abort (or pReset) in the cycle holding the n-th enabled bit.
   task automatic cut_load(input string nm, input int n, input bit use_reset);
      int ens, dones, late_aborts, ready_seen;
      ens = 0; dones = 0; late_aborts = 0; ready_seen = 0;
      @(negedge prog_clk);
      start = 1'b1; bs.bs_valid = 1'b1; bs.bs_data = 8'hC3;
      for (int c = 0; c < 100 && ens < n; c++) begin
         @(negedge prog_clk);
         start = 1'b0;
         if (ccff_clk_en) ens++;
         if (done) dones++;
      end
      chk({nm, ".reached_bit"}, ens, n);
      if (use_reset) pReset = 1'b1; else abort = 1'b1;
      @(negedge prog_clk);
      pReset = 1'b0; abort = 1'b0;
      if (use_reset) begin
         chk({nm, ".outputs_zero"},
             {bs.bs_ready, ccff_head, ccff_clk_en, busy, done, cfg_loaded, aborted, tail_parity}, 8'h00);
      end else begin
         chk({nm, ".aborted"}, aborted,     1'b1);
         chk({nm, ".busy"},    busy,        1'b0);
         chk({nm, ".clk_en"},  ccff_clk_en, 1'b0);
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge prog_clk);
         if (done)        dones++;
         if (aborted)     late_aborts++;
         if (bs.bs_ready) ready_seen++;
      end
      bs.bs_valid = 1'b0;
      chk({nm, ".no_done"},    dones,       0);
      chk({nm, ".pulse_once"}, late_aborts, 0);
      chk({nm, ".no_ready"},   ready_seen,  0);
      chk({nm, ".cfg_loaded"}, cfg_loaded,  1'b0);
   endtask

   vec_t tbl [3];

   initial begin
      logic [WORD_W-1:0] rw0, rw1;
      int rg0, rg1;
      tbl[0] = '{w0: 8'hA5, w1: 8'h03, g0: 0, g1: 0, exp_seq: 10'h3A5, exp_lat: 14, exp_par: 1'b0};
      tbl[1] = '{w0: 8'hA5, w1: 8'h03, g0: 0, g1: 5, exp_seq: 10'h3A5, exp_lat: 19, exp_par: 1'b0};
      tbl[2] = '{w0: 8'hFF, w1: 8'h00, g0: 0, g1: 0, exp_seq: 10'h0FF, exp_lat: 14, exp_par: 1'b0};

      pReset = 1'b1; start = 1'b0; abort = 1'b0;
      bs.bs_valid = 1'b0; bs.bs_data = '0;
      repeat (3) @(negedge prog_clk);
      chk("reset.outputs",
          {bs.bs_ready, ccff_head, ccff_clk_en, busy, done, cfg_loaded, aborted, tail_parity}, 8'h00);
      pReset = 1'b0;
      @(negedge prog_clk);
      chk("idle.ready", bs.bs_ready, 1'b0);

      for (int i = 0; i < 3; i++) begin
         do_load($sformatf("tbl%0d", i), tbl[i].w0, tbl[i].w1, tbl[i].g0, tbl[i].g1, 1'b0,
                 tbl[i].exp_seq, tbl[i].exp_lat, tbl[i].exp_par);
      end

      cut_load("abort4", 4, 1'b0);
      do_load("after_abort", 8'h5A, 8'h02, 0, 0, 1'b0, model_seq(8'h5A, 8'h02),
              CHAIN_LEN + NWORDS + 2, ^chain);

      cut_load("abort_last", CHAIN_LEN, 1'b0);

      do_load("start_ignored", 8'h3C, 8'h01, 0, 0, 1'b1, model_seq(8'h3C, 8'h01),
              CHAIN_LEN + NWORDS + 2, ^chain);

      @(negedge prog_clk);
      start = 1'b1; abort = 1'b1;
      @(negedge prog_clk);
      start = 1'b0; abort = 1'b0;
      chk("start_abort.busy",    busy,        1'b0);
      chk("start_abort.aborted", aborted,     1'b0);
      chk("start_abort.ready",   bs.bs_ready, 1'b0);
      chk("start_abort.cfg",     cfg_loaded,  1'b1);

      cut_load("reset_mid", 3, 1'b1);

      for (int r = 0; r < 8; r++) begin
         rw0 = 8'($urandom);
         rw1 = 8'($urandom);
         rg0 = $urandom_range(0, 3);
         rg1 = $urandom_range(0, 3);
         do_load($sformatf("rand%0d", r), rw0, rw1, rg0, rg1, 1'b0, model_seq(rw0, rw1),
                 CHAIN_LEN + NWORDS + 2 + rg0 + rg1, ^chain);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
